// File: rtl/i2c_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_wb_arbiter
// Description : Shares the single Wishbone slave port of the I2C master core
//               between two requesters. Ownership is granted per I2C
//               transaction (req held from START to STOP), with round-robin
//               tie breaking, a bus-stall watchdog that revokes a stuck
//               grant, and isolation of read data / ack / interrupt so that
//               the non-owner never observes core traffic.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TMO_W       width of the watchdog counter
//   TMO_CYCLES  max cycles one strobed bus cycle may wait for s_ack
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   m0_* / m1_*              requester side: req/gnt handshake, WB master
//                            signals in, ack/dat_r/inta out (owner gated),
//                            err = one-cycle pulse when watchdog revokes
//   s_*                      core side WB slave port
//   owner                    index of current / last granted requester
//   busy                     a grant is active
// ============================================================================
module i2c_wb_arbiter #(
    parameter int               TMO_W      = 16,
    parameter logic [TMO_W-1:0] TMO_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       m0_req,
    output logic       m0_gnt,
    input  logic [2:0] m0_adr,
    input  logic [7:0] m0_dat_w,
    output logic [7:0] m0_dat_r,
    input  logic       m0_we,
    input  logic       m0_stb,
    input  logic       m0_cyc,
    output logic       m0_ack,
    output logic       m0_inta,
    output logic       m0_err,

    input  logic       m1_req,
    output logic       m1_gnt,
    input  logic [2:0] m1_adr,
    input  logic [7:0] m1_dat_w,
    output logic [7:0] m1_dat_r,
    input  logic       m1_we,
    input  logic       m1_stb,
    input  logic       m1_cyc,
    output logic       m1_ack,
    output logic       m1_inta,
    output logic       m1_err,

    output logic [2:0] s_adr,
    output logic [7:0] s_dat_w,
    input  logic [7:0] s_dat_r,
    output logic       s_we,
    output logic       s_stb,
    output logic       s_cyc,
    input  logic       s_ack,
    input  logic       s_inta,

    output logic       owner,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    // Watchdog fires on the cycle the counter shows TMO_CYCLES-1, i.e. on
    // the TMO_CYCLES-th consecutive stalled cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYCLES - 1'b1;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic             m0_gnt_q, m1_gnt_q;
    logic             m0_err_q, m0_err_d;
    logic             m1_err_q, m1_err_d;
    logic [TMO_W-1:0] wdog_q, wdog_d;

    // Signals of whichever requester currently holds the grant. Only
    // meaningful in ST_GNT0 / ST_GNT1.
    logic own_sel;
    logic own_req;
    logic own_cyc;
    logic own_stb;
    logic own_stall;

    assign own_sel   = (state_q == ST_GNT1);
    assign own_req   = own_sel ? m1_req : m0_req;
    assign own_cyc   = own_sel ? m1_cyc : m0_cyc;
    assign own_stb   = own_sel ? m1_stb : m0_stb;
    // An ack in the expiry cycle clears the stall, so ack wins over timeout.
    assign own_stall = own_cyc & own_stb & ~s_ack;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        wdog_d   = '0;
        m0_err_d = 1'b0;
        m1_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // On a tie the requester that did not own the bus last wins.
                if (m0_req && (!m1_req || last_q)) begin
                    state_d = ST_GNT0;
                    owner_d = 1'b0;
                end else if (m1_req) begin
                    state_d = ST_GNT1;
                    owner_d = 1'b1;
                end
            end

            ST_GNT0, ST_GNT1: begin
                if (own_stall && (wdog_q == TMO_LAST)) begin
                    state_d  = ST_REL;
                    last_d   = own_sel;
                    m0_err_d = ~own_sel;
                    m1_err_d = own_sel;
                end else if (!own_req && !own_cyc) begin
                    // Release only between bus cycles so that a dropped
                    // req never aborts an in-flight access.
                    state_d = ST_REL;
                    last_d  = own_sel;
                end else if (own_stall) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            ST_REL: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus mux: purely a function of the registered state, so nothing
    // reaches the core or a requester outside a grant.
    // ------------------------------------------------------------------
    always_comb begin
        s_adr    = 3'd0;
        s_dat_w  = 8'h00;
        s_we     = 1'b0;
        s_stb    = 1'b0;
        s_cyc    = 1'b0;
        m0_ack   = 1'b0;
        m0_dat_r = 8'h00;
        m0_inta  = 1'b0;
        m1_ack   = 1'b0;
        m1_dat_r = 8'h00;
        m1_inta  = 1'b0;

        case (state_q)
            ST_GNT0: begin
                s_adr    = m0_adr;
                s_dat_w  = m0_dat_w;
                s_we     = m0_we;
                s_stb    = m0_stb;
                s_cyc    = m0_cyc;
                m0_ack   = s_ack;
                m0_dat_r = s_dat_r;
                m0_inta  = s_inta;
            end
            ST_GNT1: begin
                s_adr    = m1_adr;
                s_dat_w  = m1_dat_w;
                s_we     = m1_we;
                s_stb    = m1_stb;
                s_cyc    = m1_cyc;
                m1_ack   = s_ack;
                m1_dat_r = s_dat_r;
                m1_inta  = s_inta;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b1;
            m0_gnt_q <= 1'b0;
            m1_gnt_q <= 1'b0;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            m0_gnt_q <= (state_d == ST_GNT0);
            m1_gnt_q <= (state_d == ST_GNT1);
            m0_err_q <= m0_err_d;
            m1_err_q <= m1_err_d;
            wdog_q   <= wdog_d;
        end
    end

    assign m0_gnt = m0_gnt_q;
    assign m1_gnt = m1_gnt_q;
    assign m0_err = m0_err_q;
    assign m1_err = m1_err_q;
    assign owner  = owner_q;
    assign busy   = m0_gnt_q | m1_gnt_q;

endmodule

`default_nettype wire

// File: doc/i2c_wb_arbiter.md
Name: i2c_wb_arbiter

Overview:
- Shares the single Wishbone slave port of the I2C master core between two independent requesters, e.g. two i2c_sys_top-style sequencers in different security domains.
- Grants whole I2C transactions, not single bus beats. A requester holds req from START through STOP so that another requester cannot interleave register accesses.
- Provides round-robin fairness, a bus-stall watchdog, and data isolation: the non-owner never sees read data or interrupts.

Parameters:
- TMO_W, 16, width of the watchdog counter.
- TMO_CYCLES, 16'd50000, maximum cycles a single strobed bus cycle may wait for s_ack before the grant is revoked.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- m0_req  in  1  requester 0 wants the bus for a transaction; held until the transaction is done
- m0_gnt  out  1  requester 0 owns the bus
- m0_adr  in  3  requester 0 WB address
- m0_dat_w  in  8  requester 0 write data
- m0_dat_r  out  8  read data to requester 0
- m0_we, m0_stb, m0_cyc  in  1 each  requester 0 WB controls
- m0_ack  out  1  ack to requester 0
- m0_inta  out  1  core interrupt, owner-gated
- m0_err  out  1  one-cycle pulse: grant revoked by watchdog
- m1_*  same set as m0_*, for requester 1
- s_adr  out  3  to core
- s_dat_w  out  8  to core
- s_dat_r  in  8  from core
- s_we, s_stb, s_cyc  out  1 each  to core
- s_ack  in  1  from core
- s_inta  in  1  from core
- owner  out  1  index of current/last owner (debug)
- busy  out  1  a grant is active

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk.
  - In reset: state=IDLE, m0_gnt=m1_gnt=0, m0_err=m1_err=0, wdog=0, last=1 (so m0 wins the first tie), owner=1, busy=0.
  - All s_* outputs are 0. All m*_ack, m*_inta and m*_dat_r are 0.
- States: IDLE, GNT0, GNT1, REL. The state register, gnt and err are registered; the bus mux is combinational from state.
- IDLE:
  - Only m0_req: go to GNT0.
  - Only m1_req: go to GNT1.
  - Both: grant the requester != last.
  - Neither: stay in IDLE.
  - Grant latency: req sampled at edge N, gnt high after edge N.
- GNTx:
  - s_adr, s_dat_w, s_we, s_stb, s_cyc = mx_* .
  - mx_ack = s_ack. mx_dat_r = s_dat_r. mx_inta = s_inta.
  - For the other requester y: ack=0, dat_r=8'h00, inta=0, and its stb/cyc are ignored (no ack is ever produced).
  - Leave to REL when mx_req=0 and mx_cyc=0 at the sampling edge.
  - If req drops while mx_cyc=1, hold the grant until cyc falls. A bus cycle is never aborted by release.
  - On leaving, last<=x.
- REL: one cycle with all s_* = 0, gnt=0, busy=0, then IDLE. This guarantees a dead cycle between owners. A pending req from either requester is evaluated in IDLE.
- Watchdog:
  - wdog increments each cycle in GNTx while s_cyc&s_stb&!s_ack; it clears otherwise.
  - When wdog reaches TMO_CYCLES-1 and s_ack is still low: next state=REL, mx_err pulses for 1 cycle, last<=x, wdog<=0.
  - The revoked requester must drop req. If it re-requests, it is rearbitrated normally.
- s_ack arriving in the same cycle as the watchdog expiry wins: there is no error and the ack is forwarded.
- s_ack while state is IDLE or REL is dropped; no requester sees it.
- Request back-to-back: after REL, if both requesters are pending, the other one is granted (round-robin). A lone requester can re-acquire after the REL cycle.
- m0_gnt and m1_gnt are never both 1. busy = (state==GNT0 || state==GNT1). owner updates on grant.
- Reset mid-transaction: s_cyc falls asynchronously, grant is lost, and no err pulse is generated.

Test Plan:
- m0_req=1 only, write PRER_LO=8'hC8 with ack after 2 cycles → m0_gnt 1 cycle after req; s_adr=0 and s_dat_w=8'hC8 during stb; m0_ack=1 for the ack cycle; m1_ack stays 0.
- m0 and m1 raise req on the same edge out of reset → m0 is granted. m0 drops req → one REL cycle with s_cyc=0 → m1_gnt=1. Next simultaneous request is granted to m0.
- m1 owns the bus and the core returns s_dat_r=8'hA5 and s_inta=1 → m1_dat_r=8'hA5 and m1_inta=1, while m0_dat_r=8'h00 and m0_inta=0. m0 strobes without a grant → no s_stb change, no m0_ack.
- m0 drops req while m0_cyc=1 and ack is pending 3 cycles → grant held until ack+cyc low, then REL. No s_cyc glitch.
- TMO_CYCLES=8, m0 strobes and the core never acks → m0_err pulses after 8 stalled cycles, s_cyc=0 the next cycle, a waiting m1 is granted after REL. Repeat with ack on cycle 8 → no err.
- Assert rst for 1 cycle while in GNT1 mid-strobe → all outputs 0 immediately. After release, simultaneous requests are granted to m0.
